// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR button receiver: debounce states,
// lane count, press-count ceiling and a saturating 8-bit add.
package ddr_pkg;

   typedef enum logic [1:0] {
      UP        = 2'd0,
      WAIT_DOWN = 2'd1,
      DOWN      = 2'd2,
      WAIT_UP   = 2'd3
   } deb_state_e;

   localparam int         DDR_N_LANES     = 4;
   localparam logic [7:0] PRESS_COUNT_MAX = 8'd255;

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, PRESS_COUNT_MAX}) ? PRESS_COUNT_MAX : sum[7:0];
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One button lane: 2-FF synchronizer, debounce FSM with registered press/release
// pulses and held level. Optional autorepeat under KEY_AUTOREPEAT_EN.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 16,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press,
   output logic release_pulse,
   output logic held
);
   import ddr_pkg::*;

   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

   logic             s1_q, s2_q;
   deb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;
   logic             rel_q, rel_d;
   logic             held_q, held_d;

`ifdef KEY_AUTOREPEAT_EN
   localparam int             RPT_W    = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
   logic [RPT_W-1:0] rpt_q, rpt_d;
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = (REPEAT_CYCLES > 0);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
         UP: if (!s2_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
               state_d = DOWN;
               press_d = 1'b1;
               cnt_d   = '0;
            end else begin
               state_d = WAIT_DOWN;
               cnt_d   = CNT_W'(1);
            end
         end
         WAIT_DOWN: if (!s2_q) begin
            if (cnt_q + 1'b1 == CNT_DONE) begin
               state_d = DOWN;
               press_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            state_d = UP;
            cnt_d   = '0;
         end
         DOWN: if (s2_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
               state_d = UP;
               rel_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               state_d = WAIT_UP;
               cnt_d   = CNT_W'(1);
            end
         end
         WAIT_UP: if (s2_q) begin
            if (cnt_q + 1'b1 == CNT_DONE) begin
               state_d = UP;
               rel_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            state_d = DOWN;
            cnt_d   = '0;
         end
         default: begin
            state_d = UP;
            cnt_d   = '0;
         end
      endcase
`ifdef KEY_AUTOREPEAT_EN
      // Repeat timer only advances while the lane stays settled in DOWN.
      rpt_d = '0;
      if (state_q == DOWN && !s2_q) begin
         if (rpt_q == RPT_LAST) press_d = 1'b1;
         else                   rpt_d   = rpt_q + 1'b1;
      end
`endif
      held_d = (state_d == DOWN) || (state_d == WAIT_UP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         state_q <= UP;
         cnt_q   <= '0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         held_q  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
         rpt_q   <= '0;
`endif
      end else begin
         s1_q    <= key_n;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         held_q  <= held_d;
`ifdef KEY_AUTOREPEAT_EN
         rpt_q   <= rpt_d;
`endif
      end
   end

   assign press         = press_q;
   assign release_pulse = rel_q;
   assign held          = held_q;

endmodule

// File: rtl/ddr_key_receiver.sv
// DDR step-button receiver: N_LANES debounced lanes plus any_press and a
// saturating press counter. Autorepeat is enabled by defining KEY_AUTOREPEAT_EN.
module ddr_key_receiver #(
   parameter int N_LANES         = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 16,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic               CLOCK_50,
   input  logic               reset_n,
   input  logic [N_LANES-1:0] key_n,
   input  logic               clr,
   output logic [N_LANES-1:0] press,
   output logic [N_LANES-1:0] release_pulse,
   output logic [N_LANES-1:0] held,
   output logic               any_press,
   output logic [7:0]         press_count
);
   import ddr_pkg::*;

   logic [7:0] count_q, count_d;
   logic [7:0] press_pop;

   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_CYCLES  (REPEAT_CYCLES),
         .CNT_W          (CNT_W)
      ) u_lane (
         .clk          (CLOCK_50),
         .rst_n        (reset_n),
         .key_n        (key_n[i]),
         .press        (press[i]),
         .release_pulse(release_pulse[i]),
         .held         (held[i])
      );
   end

   // Counts the pulses currently on press; clr discards them.
   always_comb begin
      press_pop = '0;
      for (int i = 0; i < N_LANES; i++) press_pop = press_pop + 8'(press[i]);
      count_d = clr ? 8'd0 : sat_add8(count_q, press_pop);
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) count_q <= 8'd0;
      else          count_q <= count_d;
   end

   assign any_press   = |press;
   assign press_count = count_q;

endmodule

// File: tb/tb_ddr_key_receiver.sv
// Self-checking bench for ddr_key_receiver: directed sequences, a vector table
// and randomized key activity checked against a run-length reference model.
module tb_ddr_key_receiver;
   localparam int NL = 4;
   localparam int D  = 4;
   localparam int R  = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          clr;
   logic [NL-1:0] key_n;
   logic [NL-1:0] press, rel, held;
   logic          any_press;
   logic [7:0]    press_count;

   always #5 clk = ~clk;

   ddr_key_receiver #(
      .N_LANES(NL), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)
   ) dut (
      .CLOCK_50     (clk),
      .reset_n      (reset_n),
      .key_n        (key_n),
      .clr          (clr),
      .press        (press),
      .release_pulse(rel),
      .held         (held),
      .any_press    (any_press),
      .press_count  (press_count)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: synchronizer as a two-deep delay line, debounce as
   // "accepted level + length of the run of samples disagreeing with it".
   logic [NL-1:0] m_s1, m_s2, m_acc, m_press, m_rel;
   int            m_run [NL];
   int            m_rc  [NL];
   int            m_cnt;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   task automatic model_reset();
      m_s1 = '1; m_s2 = '1; m_acc = '0; m_press = '0; m_rel = '0; m_cnt = 0;
      for (int i = 0; i < NL; i++) begin m_run[i] = 0; m_rc[i] = 0; end
   endtask

   task automatic model_edge();
      int  pc;
      logic down;
      bit  steady;
      if (!reset_n) begin
         model_reset();
         return;
      end
      pc    = $countones(m_press);
      m_cnt = clr ? 0 : ((m_cnt + pc > 255) ? 255 : m_cnt + pc);
      for (int i = 0; i < NL; i++) begin
         down       = !m_s2[i];
         m_press[i] = 1'b0;
         m_rel[i]   = 1'b0;
         if (down != m_acc[i]) begin
            m_rc[i] = 0;
            m_run[i]++;
            if (m_run[i] == D) begin
               m_acc[i] = down;
               m_run[i] = 0;
               if (down) m_press[i] = 1'b1;
               else      m_rel[i]   = 1'b1;
            end
         end else begin
            steady   = (m_run[i] == 0);
            m_run[i] = 0;
`ifdef KEY_AUTOREPEAT_EN
            if (m_acc[i] && steady) begin
               m_rc[i]++;
               if (m_rc[i] == R) begin m_press[i] = 1'b1; m_rc[i] = 0; end
            end else begin
               m_rc[i] = 0;
            end
`else
            if (steady) m_rc[i] = 0;
`endif
         end
      end
      m_s2 = m_s1;
      m_s1 = key_n;
   endtask

   task automatic compare_all();
      check("press",       32'(press),       32'(m_press));
      check("release",     32'(rel),         32'(m_rel));
      check("held",        32'(held),        32'(m_acc));
      check("any_press",   32'(any_press),   32'(|m_press));
      check("press_count", 32'(press_count), 32'(m_cnt));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic settle(int n);
      key_n = '1;
      for (int k = 0; k < n; k++) step();
   endtask

   typedef struct {
      logic [NL-1:0] mask;
      int            low;
      int            exp_press;
      int            exp_rel;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int first, cnt_p, cnt_r, c0;
      int pr[$];

      reset_n = 1'b0; clr = 1'b0; key_n = '1;
      model_reset();
      for (int k = 0; k < 3; k++) step();
      reset_n = 1'b1;
      check("reset_count", 32'(press_count), 32'd0);
      check("reset_held",  32'(held),        32'd0);
      settle(4);

      // Clean press on lane 0: latency, held and count.
      key_n[0] = 1'b0;
      first = -1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (press[0] && first < 0) first = k;
      end
      check("press_latency", 32'(first), 32'(D + 2));
      check("held0_down",    32'(held[0]), 32'd1);
      check("count_one",     32'(press_count), 32'd1);
      key_n[0] = 1'b1;
      first = -1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (rel[0] && first < 0) first = k;
      end
      check("release_latency", 32'(first), 32'(D + 2));
      check("held0_up",        32'(held[0]), 32'd0);

      // Bounce on lane 1: low 3, high 1, low 10.
      first = -1; cnt_p = 0; cnt_r = 0;
      for (int k = 1; k <= 14; k++) begin
         key_n[1] = (k == 4) ? 1'b1 : 1'b0;
         step();
         if (press[1] && first < 0) first = k;
         cnt_p += press[1];
         cnt_r += rel[1];
      end
      check("bounce_latency", 32'(first), 32'(5 + D + 1));
      check("bounce_presses", 32'(cnt_p), 32'd1);
      check("bounce_release", 32'(cnt_r), 32'd0);
      settle(12);

      // All four lanes fall together.
      c0 = press_count;
      key_n = '0;
      first = -1;
      for (int k = 1; k <= 12 && first < 0; k++) begin
         step();
         if (any_press) first = k;
      end
      check("simul_seen",  32'(first), 32'(D + 2));
      check("simul_press", 32'(press), 32'hF);
      step();
      check("simul_count", 32'(press_count), 32'(c0 + 4));
      check("simul_once",  32'(press), 32'h0);
      settle(12);

      // Reset while lane 2 is in the middle of debouncing.
      key_n[2] = 1'b0;
      for (int k = 0; k < 3; k++) step();
      reset_n = 1'b0;
      #1;
      model_reset();
      check("rst_press", 32'(press),       32'd0);
      check("rst_held",  32'(held),        32'd0);
      check("rst_count", 32'(press_count), 32'd0);
      for (int k = 0; k < 2; k++) step();
      reset_n = 1'b1;
      first = -1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (press[2] && first < 0) first = k;
      end
      check("rst_repress", 32'(first), 32'(D + 2));
      settle(12);

      // Vector table: lane mask held low for a number of cycles.
      tbl[0] = '{4'b0001, 8,  1, 1};
      tbl[1] = '{4'b0010, 3,  0, 0};
      tbl[2] = '{4'b0100, 4,  1, 1};
      tbl[3] = '{4'b1000, 1,  0, 0};
      tbl[4] = '{4'b1111, 6,  4, 4};
      tbl[5] = '{4'b0101, 10, 2, 2};
      tbl[6] = '{4'b1010, 2,  0, 0};
      tbl[7] = '{4'b0011, 5,  2, 2};
      for (int v = 0; v < 8; v++) begin
         cnt_p = 0; cnt_r = 0;
         key_n = ~tbl[v].mask;
         for (int k = 0; k < tbl[v].low + 14; k++) begin
            if (k == tbl[v].low) key_n = '1;
            step();
            cnt_p += $countones(press);
            cnt_r += $countones(rel);
         end
         check($sformatf("vec%0d_press", v),   32'(cnt_p), 32'(tbl[v].exp_press));
         check($sformatf("vec%0d_release", v), 32'(cnt_r), 32'(tbl[v].exp_rel));
      end

      // Saturation then clear.
      for (int p = 0; p < 64; p++) begin
         key_n = '0;
         for (int k = 0; k < 8; k++) step();
         key_n = '1;
         for (int k = 0; k < 8; k++) step();
      end
      check("sat_255", 32'(press_count), 32'd255);
      settle(4);
      check("sat_hold", 32'(press_count), 32'd255);
      clr = 1'b1; step(); clr = 1'b0;
      check("clr_zero", 32'(press_count), 32'd0);

      // clr coincident with press on lanes 0 and 1.
      key_n = 4'b1100;
      first = -1;
      for (int k = 1; k <= 12 && first < 0; k++) begin
         step();
         if (press != 0) first = k;
      end
      check("clr_press_seen", 32'(press), 32'h3);
      clr = 1'b1; step(); clr = 1'b0;
      check("clr_discard", 32'(press_count), 32'd0);
      step();
      check("clr_discard2", 32'(press_count), 32'd0);
      settle(12);

      // Long hold on lane 3: autorepeat behaviour.
      key_n = 4'b0111;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (press[3]) pr.push_back(k);
      end
      settle(12);
`ifdef KEY_AUTOREPEAT_EN
      check("rpt_count", 32'(pr.size()), 32'd3);
      if (pr.size() >= 3) begin
         check("rpt_first", 32'(pr[0]), 32'(D + 2));
         check("rpt_gap1",  32'(pr[1] - pr[0]), 32'(R));
         check("rpt_gap2",  32'(pr[2] - pr[1]), 32'(R));
      end
`else
      check("rpt_count", 32'(pr.size()), 32'd1);
      if (pr.size() >= 1) check("rpt_first", 32'(pr[0]), 32'(D + 2));
`endif

      // Randomized key activity with occasional clr.
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < NL; i++)
            if ($urandom_range(0, 5) == 0) key_n[i] = ~key_n[i];
         clr = ($urandom_range(0, 49) == 0);
         step();
      end
      clr = 1'b0;
      settle(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
